cellram_access_sequencer: RTL

// - Sequences asynchronous-mode accesses to the external 16-bit cellular RAM and shares it between
//   the audio record path (writer) and the playback path (reader).
// - Drives the active-low memory strobes, address, and data-bus direction directly.
// - Sits between the audio sample buffers and the board memory pins.

---
 rtl/cellram_access_sequencer_pkg.sv | 32 +++
 rtl/cellram_access_sequencer_if.sv | 30 +++
 rtl/cellram_access_sequencer_rr_arbiter.sv | 41 ++++
 rtl/cellram_access_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cellram_access_sequencer_pkg.sv
// Shared types and defaults for the cellular RAM access sequencer:
// FSM state encodings, grant encodings, default 50 MHz timing and a small helper.
package cellram_access_sequencer_pkg;

   // Default geometry and timing for the 50 MHz system clock
   localparam int DEF_ADDR_W      = 23;
   localparam int DEF_DATA_W      = 16;
   localparam int DEF_ACCESS_CYC  = 4;   // 4 x 20 ns covers 70 ns tAA/tWP
   localparam int DEF_RECOVER_CYC = 1;

   // Bit positions of the two requesters in the arbiter request/grant vectors
   localparam int IDX_RD = 0;
   localparam int IDX_WR = 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_ACCESS  = 3'd2,
      ST_HOLD    = 3'd3,
      ST_RECOVER = 3'd4
   } state_e;

   typedef enum logic {
      GNT_RD = 1'b0,
      GNT_WR = 1'b1
   } grant_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cellram_access_sequencer_if.sv
// Requester-side bus of the cellular RAM sequencer: one write port and one read port.
// master = the audio buffers issuing requests, slave = the sequencer serving them.
interface cellram_access_sequencer_if
   import cellram_access_sequencer_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [1:0]        wr_be;
   logic              wr_ack;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;

   modport master (
      output wr_req, wr_addr, wr_data, wr_be, rd_req, rd_addr,
      input  wr_ack, rd_data, rd_valid
   );

   modport slave (
      input  wr_req, wr_addr, wr_data, wr_be, rd_req, rd_addr,
      output wr_ack, rd_data, rd_valid
   );

endinterface

// File: rtl/cellram_access_sequencer_rr_arbiter.sv
// cellram_rr_arbiter: two-way round robin between reader (bit 0) and writer (bit 1).
// A lone requester always wins; under contention the side not granted last wins.
module cellram_rr_arbiter
   import cellram_access_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt,
   output grant_e     last_grant
);

   grant_e last_grant_reg;

   // Combinational grant: alternate only when both sides are asking
   always_comb begin
      gnt = req;
      if (req[IDX_RD] && req[IDX_WR]) begin
         gnt = 2'b00;
         if (last_grant_reg == GNT_WR) begin
            gnt[IDX_RD] = 1'b1;
         end else begin
            gnt[IDX_WR] = 1'b1;
         end
      end
   end

   // Remember the winner each time a grant is actually taken; WRITE at reset
   // so the first contention goes to the reader
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_reg <= GNT_WR;
      end else if (advance) begin
         last_grant_reg <= gnt[IDX_WR] ? GNT_WR : GNT_RD;
      end
   end

   assign last_grant = last_grant_reg;

endmodule

// File: rtl/cellram_access_sequencer.sv
// cellram_access_sequencer: asynchronous-mode access sequencer for the external 16-bit
// cellular RAM, shared between the audio record (write) and playback (read) paths.
// All memory pins are registered so strobes never glitch; async reset forces them idle.
// Optional macro CELLRAM_BYTE_LANE_EN: writes drive UB/LB from wr_be, and a write with
// no lanes enabled is acknowledged without pulsing WE.
module cellram_access_sequencer
   import cellram_access_sequencer_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ACCESS_CYC  = DEF_ACCESS_CYC,
   parameter int RECOVER_CYC = DEF_RECOVER_CYC
)(
   input  logic                      clk,
   input  logic                      rst_n,
   cellram_access_sequencer_if.slave bus,
   output logic                      busy,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic [DATA_W-1:0]         mem_dq_i,
   output logic [DATA_W-1:0]         mem_dq_o,
   output logic                      mem_dq_oe,
   output logic                      mem_CE,
   output logic                      mem_OE,
   output logic                      mem_WE,
   output logic                      mem_UB,
   output logic                      mem_LB,
   output logic                      mem_ADV,
   output logic                      mem_CRE
);

   localparam int CNT_W = $clog2(max_int(ACCESS_CYC, RECOVER_CYC) + 1);
   localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYC - 1);
   localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'((RECOVER_CYC > 0) ? RECOVER_CYC - 1 : 0);

   state_e           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [1:0]       req, gnt;
   grant_e           unused_last_grant;
   logic             grant_fire;
   logic             dir_wr_reg, dir_next;
   logic             ce_next, oe_next, we_next, ub_next, lb_next, dq_oe_next;
   logic             wr_ack_next, rd_valid_next;
   logic             wr_ack_reg, rd_valid_reg;
   logic [DATA_W-1:0] rd_data_reg;
   logic             we_allowed;
`ifdef CELLRAM_BYTE_LANE_EN
   logic [1:0]       be_reg, be_next;
`else
   logic             unused_be;
   assign unused_be = ^bus.wr_be;
`endif

   assign req[IDX_RD] = bus.rd_req;
   assign req[IDX_WR] = bus.wr_req;
   assign grant_fire  = (state_reg == ST_IDLE) && (|req);

   cellram_rr_arbiter u_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .advance    (grant_fire),
      .gnt        (gnt),
      .last_grant (unused_last_grant)
   );

   // Direction (and lanes) of the access being started or in flight
   assign dir_next = grant_fire ? gnt[IDX_WR] : dir_wr_reg;
`ifdef CELLRAM_BYTE_LANE_EN
   assign be_next    = (grant_fire && gnt[IDX_WR]) ? bus.wr_be : be_reg;
   assign we_allowed = |be_next;
`else
   assign we_allowed = 1'b1;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic: SETUP and HOLD are single cycles, ACCESS/RECOVER run on the counter
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:    if (|req) state_next = ST_SETUP;
         ST_SETUP:   state_next = ST_ACCESS;
         ST_ACCESS:  if (cnt_reg == '0) state_next = ST_HOLD;
         ST_HOLD:    state_next = (RECOVER_CYC == 0) ? ST_IDLE : ST_RECOVER;
         ST_RECOVER: if (cnt_reg == '0) state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // Cycle counter: reloads on every state entry, then counts down to zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (state_next != state_reg) begin
         case (state_next)
            ST_ACCESS:  cnt_reg <= ACC_LOAD;
            ST_RECOVER: cnt_reg <= REC_LOAD;
            default:    cnt_reg <= '0;
         endcase
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   // Output decode of the upcoming state; results are registered onto the pins below
   always_comb begin
      ce_next       = 1'b1;
      oe_next       = 1'b1;
      we_next       = 1'b1;
      ub_next       = 1'b1;
      lb_next       = 1'b1;
      dq_oe_next    = 1'b0;
      wr_ack_next   = 1'b0;
      rd_valid_next = 1'b0;
      case (state_next)
         ST_SETUP, ST_ACCESS, ST_HOLD: begin
            ce_next    = 1'b0;
            ub_next    = 1'b0;
            lb_next    = 1'b0;
`ifdef CELLRAM_BYTE_LANE_EN
            if (dir_next) begin
               ub_next = ~be_next[1];
               lb_next = ~be_next[0];
            end
`endif
            dq_oe_next = dir_next;
            if (state_next == ST_ACCESS) begin
               if (dir_next) we_next = ~we_allowed;
               else          oe_next = 1'b0;
            end
            if (state_next == ST_HOLD) begin
               wr_ack_next   = dir_next;
               rd_valid_next = ~dir_next;
            end
         end
         default: ;
      endcase
   end

   // Pin and handshake registers; reset parks every strobe high and releases DQ
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_CE       <= 1'b1;
         mem_OE       <= 1'b1;
         mem_WE       <= 1'b1;
         mem_UB       <= 1'b1;
         mem_LB       <= 1'b1;
         mem_dq_oe    <= 1'b0;
         wr_ack_reg   <= 1'b0;
         rd_valid_reg <= 1'b0;
         busy         <= 1'b0;
      end else begin
         mem_CE       <= ce_next;
         mem_OE       <= oe_next;
         mem_WE       <= we_next;
         mem_UB       <= ub_next;
         mem_LB       <= lb_next;
         mem_dq_oe    <= dq_oe_next;
         wr_ack_reg   <= wr_ack_next;
         rd_valid_reg <= rd_valid_next;
         busy         <= (state_next != ST_IDLE);
      end
   end

   // Capture the granted request at the IDLE edge and read data at the end of ACCESS
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr    <= '0;
         mem_dq_o    <= '0;
         dir_wr_reg  <= 1'b0;
         rd_data_reg <= '0;
`ifdef CELLRAM_BYTE_LANE_EN
         be_reg      <= 2'b00;
`endif
      end else begin
         if (grant_fire) begin
            dir_wr_reg <= gnt[IDX_WR];
            if (gnt[IDX_WR]) begin
               mem_addr <= bus.wr_addr;
               mem_dq_o <= bus.wr_data;
            end else begin
               mem_addr <= bus.rd_addr;
            end
         end
`ifdef CELLRAM_BYTE_LANE_EN
         be_reg <= be_next;
`endif
         if (state_reg == ST_ACCESS && cnt_reg == '0 && !dir_wr_reg) begin
            rd_data_reg <= mem_dq_i;
         end
      end
   end

   assign bus.wr_ack   = wr_ack_reg;
   assign bus.rd_valid = rd_valid_reg;
   assign bus.rd_data  = rd_data_reg;
   assign mem_ADV      = 1'b0;
   assign mem_CRE      = 1'b0;

endmodule
